// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state codes, seven-segment patterns and the double-dabble digit adjust.
package bin2bcd_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_SHIFT = 1'b1;

    // Active-high {g,f,e,d,c,b,a} patterns for decimal digits 0..9
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [3:0] dd_adjust(input logic [3:0] digit);
        return (digit >= 4'd5) ? digit + 4'd3 : digit;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// One BCD code to one active-high seven-segment pattern, with forced blanking.
module seg7_decode
    import bin2bcd_pkg::*;
(
    input  logic [3:0] code,
    input  logic       blank,
    output logic [6:0] seg
);

    // Codes A..F never come out of a valid conversion and show nothing
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (code)
                4'd0:    seg = SEG_DIGIT[0];
                4'd1:    seg = SEG_DIGIT[1];
                4'd2:    seg = SEG_DIGIT[2];
                4'd3:    seg = SEG_DIGIT[3];
                4'd4:    seg = SEG_DIGIT[4];
                4'd5:    seg = SEG_DIGIT[5];
                4'd6:    seg = SEG_DIGIT[6];
                4'd7:    seg = SEG_DIGIT[7];
                4'd8:    seg = SEG_DIGIT[8];
                4'd9:    seg = SEG_DIGIT[9];
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seq_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter, one iteration per clock,
// with start/busy/done handshake, overflow flag and seven-segment outputs.
module seq_bin2bcd
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W    = 8,
    parameter int DIGITS   = 3,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             state;
    logic [SR_W-1:0]    sr;
    logic [SR_W-1:0]    sr_adj;
    logic [SR_W-1:0]    sr_next;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_acc;
    logic               shift_out;
    logic               last_iter;
    logic [DIGITS-1:0]  blank;
    logic               zero_above;

    // The bit leaving the top digit is a carry into a digit we do not keep
    always_comb begin
        sr_adj = sr;
        for (int k = 0; k < DIGITS; k++) begin
            sr_adj[BIN_W + 4*k +: 4] = dd_adjust(sr[BIN_W + 4*k +: 4]);
        end
        shift_out = sr_adj[SR_W-1];
        sr_next   = {sr_adj[SR_W-2:0], 1'b0};
        last_iter = (cnt == CNT_W'(BIN_W - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            sr      <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
            bcd     <= '0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (start) begin
                    sr      <= {BCD_W'(0), bin};
                    cnt     <= '0;
                    ovf_acc <= 1'b0;
                    state   <= ST_SHIFT;
                end
            end else begin
                sr      <= sr_next;
                cnt     <= cnt + CNT_W'(1);
                ovf_acc <= ovf_acc | shift_out;
                if (last_iter) begin
                    bcd   <= sr_next[SR_W-1 -: BCD_W];
                    ovf   <= ovf_acc | shift_out;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
            end
        end
    end

    assign busy = (state == ST_SHIFT);

    // A digit is a leading zero when it and every digit above it is zero
    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above & (bcd[4*k +: 4] == 4'd0);
            blank[k]   = BLANK_LZ & zero_above;
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        seg7_decode u_dec (
            .code  (bcd[4*k +: 4]),
            .blank (blank[k]),
            .seg   (seg[7*k +: 7])
        );
    end

endmodule
